rsa_byte_frontend: RTL and testbench
====================================

# rsa_byte_frontend

Byte-stream front end for the 256-bit modular-exponentiation core. Sits directly upstream and downstream of the core:
- Assembles the modulus `n`, the exponent `e` and successive 256-bit ciphertext blocks from an 8-bit valid/ready receive stream.
- Pulses the core's start input and holds its operands stable while the core runs.
- Captures the result and returns it as a 31-byte plaintext block on an 8-bit valid/ready transmit stream.

The key (`n`, `e`) is loaded once per reset; after that, any number of ciphertext blocks are processed back to back.

## Interface
Parameters:
- `BYTES_IN`, 32: bytes per received word (`n`, `e`, ciphertext); fixed by the 256-bit core width.
- `BYTES_OUT`, 31: plaintext bytes transmitted per block, taken from result bits [247:0].

Ports:
- `i_clk`  in  1  single clock; all logic on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  8  received byte, MSB-first within each word.
- `i_rx_valid`  in  1  `i_rx_data` valid.
- `o_rx_ready`  out  1  block accepts a byte this cycle.
- `o_tx_data`  out  8  plaintext byte, MSB-first.
- `o_tx_valid`  out  1  `o_tx_data` valid.
- `i_tx_ready`  in  1  sink accepts the byte this cycle.
- `o_core_start`  out  1  one-cycle start pulse to the core.
- `o_core_a`  out  256  ciphertext block.
- `o_core_e`  out  256  exponent.
- `o_core_n`  out  256  modulus.
- `i_core_result`  in  256  core result; valid on and after the `i_core_finished` cycle.
- `i_core_finished`  in  1  one-cycle completion pulse from the core.

## Operation
- State machine states: S_N, S_E, S_C, S_START, S_WAIT, S_TX.
- Receive states are S_N, S_E and S_C:
  - `o_rx_ready` = 1 in these states; 0 in all other states.
  - A byte is accepted when `i_rx_valid` & `o_rx_ready`.
  - On accept, the target register is updated as `reg <= {reg[247:0], i_rx_data}` and the 5-bit byte counter increments.
  - The byte counter wraps 31 -> 0 on the 32nd accept of a word.
- S_N: target `n`; the 32nd accept moves to S_E.
- S_E: target `e`; the 32nd accept moves to S_C.
- S_C: target `a`; the 32nd accept moves to S_START.
- S_START: `o_core_start` = 1 for exactly this one cycle; next state is S_WAIT.
- S_WAIT:
  - On `i_core_finished` = 1, load the tx shift register with `i_core_result` and clear the tx counter.
  - Next state is S_TX.
- S_TX:
  - `o_tx_valid` = 1 and `o_tx_data` = `txreg[247:240]`.
  - On `i_tx_ready`, shift `txreg` left by 8 and increment the tx counter.
  - After the 31st accepted byte, go to S_C.
  - `n` and `e` are retained across blocks.
- `i_core_finished` is ignored outside S_WAIT.
- Result bits [255:248] are never transmitted.
- `o_core_a`, `o_core_e` and `o_core_n` are driven directly from the registers. They change only during receive states, so they are stable for the whole of S_START and S_WAIT.
- `o_tx_data` is stable while `o_tx_valid` = 1 and `i_tx_ready` = 0.
- `o_tx_valid` never drops before its byte is accepted.

## Timing
- Reset, when `i_rst` = 1 at a clock edge:
  - state becomes S_N, counters become 0, the `n`/`e`/`a`/tx registers become 0.
  - Outputs after reset: `o_core_start` = 0, `o_tx_valid` = 0, `o_tx_data` = 0, `o_rx_ready` = 1, core operand outputs = 0.
- Reset has priority over every event, including mid-word, in S_WAIT and in S_TX.
  - A pending transmit is dropped.
  - The key must be reloaded after reset.
- Throughput: one byte per cycle on each stream when the partner is always ready.
- Start latency: the 32nd ciphertext byte accepted at edge k -> `o_core_start` high in cycle k+1 -> S_WAIT from k+2.
- Transmit latency: `i_core_finished` sampled at edge m -> `o_tx_valid` high from cycle m+1.
- An idle `i_rx_valid` or `i_tx_ready` stalls the machine indefinitely; no timeout.
- S_TX to S_C: `o_rx_ready` rises in the cycle after the last tx accept; rx and tx never overlap.
- `i_rx_valid` held high in non-receive states: no byte is consumed.

## Test plan
- Bench uses a behavioural core model: result = a^e mod n, finished pulsed 20 cycles after start.
- Basic block:
  - Stimulus: `n` = 253, `e` = 3, `a` = 5, each as 32 bytes with leading 0x00.
  - Required: exactly one `o_core_start` pulse, with `o_core_n` = 253, `o_core_e` = 3, `o_core_a` = 5 at that cycle.
  - Required: `o_tx` emits 30×0x00 then 0x7D, then `o_rx_ready` = 1.
- Back-to-back blocks:
  - Stimulus: after the basic block, send `a` = 2 (no key reload).
  - Required: `o_core_e` still = 3; second output 30×0x00 then 0x08.
- Backpressure:
  - Stimulus: `i_tx_ready` toggled 1 cycle on, 2 off; `i_rx_valid` random 50%.
  - Required: same bytes as the basic block, each byte held stable until accepted, no duplicates.
- Top byte dropped:
  - Stimulus: the core model returns 0xAB followed by 31×0x11.
  - Required: `o_tx` emits 31×0x11, and 0xAB never appears.
- Reset mid-operation:
  - Stimulus: assert `i_rst` for 1 cycle during S_WAIT, then again at tx byte 10.
  - Required: `o_tx_valid` = 0 the next cycle, state S_N, and subsequent `finished` pulses ignored until a full reload.
- Spurious finished:
  - Stimulus: pulse `i_core_finished` during S_N and S_C.
  - Required: no `o_tx_valid`, and the receive byte count is unaffected.

Source files
------------

// File: rtl/rsa_byte_frontend.sv
// rsa_byte_frontend: byte-stream wrapper around the 256-bit modexp core.
// Receives n, e and ciphertext blocks MSB-first over an 8-bit valid/ready
// stream, starts the core, and returns the low 31 result bytes over an
// 8-bit valid/ready transmit stream. The key is loaded once per reset.
module rsa_byte_frontend #(
    parameter int BYTES_IN  = 32,
    parameter int BYTES_OUT = 31
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_core_start,
    output logic [8*BYTES_IN-1:0] o_core_a,
    output logic [8*BYTES_IN-1:0] o_core_e,
    output logic [8*BYTES_IN-1:0] o_core_n,
    input  logic [8*BYTES_IN-1:0] i_core_result,
    input  logic                  i_core_finished
);

    localparam int         WIN     = 8 * BYTES_IN;
    localparam int         WOUT    = 8 * BYTES_OUT;
    localparam logic [4:0] RX_LAST = 5'(BYTES_IN - 1);
    localparam logic [4:0] TX_LAST = 5'(BYTES_OUT - 1);

    typedef enum logic [2:0] {
        S_N,
        S_E,
        S_C,
        S_START,
        S_WAIT,
        S_TX
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIN-1:0]  n_reg;
    logic [WIN-1:0]  e_reg;
    logic [WIN-1:0]  a_reg;
    logic [WOUT-1:0] tx_reg;
    logic [4:0]      rx_count;
    logic [4:0]      tx_count;
    logic            rx_accept;
    logic            tx_accept;
    logic            result_top_unused;

    // The top result byte is never transmitted; fold it away explicitly.
    assign result_top_unused = ^i_core_result[WIN-1:WOUT];

    assign rx_accept = i_rx_valid && o_rx_ready;
    assign tx_accept = o_tx_valid && i_tx_ready;

    assign o_core_n  = n_reg;
    assign o_core_e  = e_reg;
    assign o_core_a  = a_reg;
    assign o_tx_data = tx_reg[WOUT-1 -: 8];

    // Handshake and start outputs are a pure decode of the current state.
    always_comb begin
        o_rx_ready   = 1'b0;
        o_tx_valid   = 1'b0;
        o_core_start = 1'b0;
        case (state)
            S_N, S_E, S_C: o_rx_ready   = 1'b1;
            S_START:       o_core_start = 1'b1;
            S_TX:          o_tx_valid   = 1'b1;
            default:       ;
        endcase
    end

    // Next-state logic: each receive state ends on the last byte of its word.
    always_comb begin
        state_next = state;
        unique case (state)
            S_N:     if (rx_accept && rx_count == RX_LAST) state_next = S_E;
            S_E:     if (rx_accept && rx_count == RX_LAST) state_next = S_C;
            S_C:     if (rx_accept && rx_count == RX_LAST) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (i_core_finished) state_next = S_TX;
            S_TX:    if (tx_accept && tx_count == TX_LAST) state_next = S_C;
            default: state_next = S_N;
        endcase
    end

    // State register; reset always returns to key loading.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_N;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: operand shift-in, result capture and transmit shift-out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            n_reg    <= '0;
            e_reg    <= '0;
            a_reg    <= '0;
            tx_reg   <= '0;
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (rx_accept) begin
                rx_count <= (rx_count == RX_LAST) ? 5'd0 : rx_count + 5'd1;
                case (state)
                    S_N:     n_reg <= {n_reg[WIN-9:0], i_rx_data};
                    S_E:     e_reg <= {e_reg[WIN-9:0], i_rx_data};
                    S_C:     a_reg <= {a_reg[WIN-9:0], i_rx_data};
                    default: ;
                endcase
            end
            if (state == S_WAIT && i_core_finished) begin
                tx_reg   <= i_core_result[WOUT-1:0];
                tx_count <= '0;
            end else if (tx_accept) begin
                tx_reg   <= {tx_reg[WOUT-9:0], 8'h00};
                tx_count <= (tx_count == TX_LAST) ? 5'd0 : tx_count + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_rsa_byte_frontend.sv
// Testbench for rsa_byte_frontend: table of blocks (directed and random)
// checked against a behavioural modexp core model and byte scoreboard,
// plus hand-written reset and spurious-finished sequences.
module tb_rsa_byte_frontend;

    typedef struct {
        bit           new_key;
        bit           bp;
        bit           rnd_rx;
        bit           hold_rx;
        bit           override;
        logic [255:0] n;
        logic [255:0] e;
        logic [255:0] a;
        logic [247:0] expect_pt;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         core_start;
    logic [255:0] core_a;
    logic [255:0] core_e;
    logic [255:0] core_n;
    logic [255:0] core_result;
    logic         core_finished;
    logic         model_finished;
    logic         spur_finished;

    int n_checks = 0;
    int n_pass = 0;
    int start_count = 0;
    bit override_top = 1'b0;
    bit expect_live = 1'b0;

    assign core_finished = model_finished | spur_finished;

    always #5 clk = ~clk;

    rsa_byte_frontend dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_data      (rx_data),
        .i_rx_valid     (rx_valid),
        .o_rx_ready     (rx_ready),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .o_core_start   (core_start),
        .o_core_a       (core_a),
        .o_core_e       (core_e),
        .o_core_n       (core_n),
        .i_core_result  (core_result),
        .i_core_finished(core_finished)
    );

    // Reference modular exponentiation by square-and-multiply.
    function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] ex,
                                            input logic [255:0] m);
        logic [511:0] r;
        logic [511:0] x;
        logic [511:0] mm;
        mm = {256'd0, m};
        r  = 512'd1 % mm;
        x  = {256'd0, b} % mm;
        for (int i = 0; i < 256; i++) begin
            if (ex[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return r[255:0];
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act,
                               input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        $display("[TB] FAIL %s: bound expired, got no completion, expected completion", name);
    endtask

    // Count every cycle the start pulse is high.
    always @(negedge clk) if (core_start) start_count <= start_count + 1;

    // Behavioural core: snapshots operands at start, finishes 20 cycles later.
    initial begin
        logic [255:0] snap_n, snap_e, snap_a;
        model_finished = 1'b0;
        core_result    = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                snap_n = core_n;
                snap_e = core_e;
                snap_a = core_a;
                repeat (20) @(negedge clk);
                core_result = override_top ? {8'hAB, {31{8'h11}}}
                                           : modexp(snap_a, snap_e, snap_n);
                model_finished = 1'b1;
                @(negedge clk);
                model_finished = 1'b0;
                if (expect_live) checkOutput("tx_latency", 256'(tx_valid), 256'(1));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_bytes(input logic [255:0] w, input int first, input int count,
                              input bit rnd);
        int i;
        int guard;
        i     = first;
        guard = 0;
        while (i < first + count && guard < 4000) begin
            @(negedge clk);
            guard++;
            rx_data  = w[255 - 8*i -: 8];
            rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rx_valid && rx_ready) i++;
        end
        if (i < first + count) report_timeout("rx_send");
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv_block(input logic [247:0] exp, input bit bp, input bit hold,
                              input logic [255:0] a_val, input int stop_after, input bit chk_ab);
        int cnt;
        int guard;
        int phase;
        bit pend;
        bit saw_ab;
        logic [7:0] pend_data;
        cnt = 0; guard = 0; phase = 0; pend = 1'b0; saw_ab = 1'b0; pend_data = '0;
        while (cnt < stop_after && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (pend) begin
                checkOutput("tx_hold_valid", 256'(tx_valid), 256'(1));
                checkOutput("tx_hold_data", 256'(tx_data), 256'(pend_data));
            end
            tx_ready = bp ? (phase == 0) : 1'b1;
            phase    = (phase + 1) % 3;
            if (hold) begin
                rx_data  = 8'hEE;
                rx_valid = 1'b1;
                checkOutput("a_stable", core_a, a_val);
            end
            if (tx_valid && tx_ready) begin
                checkOutput("tx_byte", 256'(tx_data), 256'(exp[247 - 8*cnt -: 8]));
                if (tx_data == 8'hAB) saw_ab = 1'b1;
                cnt++;
                pend = 1'b0;
                if (hold && cnt == 31) rx_valid = 1'b0;
            end else begin
                pend      = tx_valid;
                pend_data = tx_data;
            end
        end
        if (cnt < stop_after) report_timeout("tx_recv");
        if (stop_after == 31) begin
            @(negedge clk);
            tx_ready = 1'b0;
            checkOutput("rx_ready_after_tx", 256'(rx_ready), 256'(1));
            checkOutput("tx_valid_after_tx", 256'(tx_valid), 256'(0));
            if (chk_ab) checkOutput("no_top_byte", 256'(saw_ab), 256'(0));
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int starts_before;
        if (v.new_key) begin
            do_reset();
            send_bytes(v.n, 0, 32, v.rnd_rx);
            send_bytes(v.e, 0, 32, v.rnd_rx);
        end
        override_top  = v.override;
        expect_live   = 1'b1;
        starts_before = start_count;
        send_bytes(v.a, 0, 32, v.rnd_rx);
        checkOutput("start_pulse", 256'(core_start), 256'(1));
        checkOutput("start_n", core_n, v.n);
        checkOutput("start_e", core_e, v.e);
        checkOutput("start_a", core_a, v.a);
        recv_block(v.expect_pt, v.bp, v.hold_rx, v.a, 31, v.override);
        checkOutput("start_count", 256'(start_count - starts_before), 256'(1));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   tx_hi;
        int   starts_before;

        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; spur_finished = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_tx_valid", 256'(tx_valid), 256'(0));
        checkOutput("reset_tx_data", 256'(tx_data), 256'(0));
        checkOutput("reset_rx_ready", 256'(rx_ready), 256'(1));
        checkOutput("reset_core_start", 256'(core_start), 256'(0));
        checkOutput("reset_core_n", core_n, 256'd0);
        checkOutput("reset_core_e", core_e, 256'd0);
        checkOutput("reset_core_a", core_a, 256'd0);

        // new_key, bp, rnd_rx, hold_rx, override, n, e, a, expected plaintext
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 256'd253, 256'd3, 256'd5, 248'h7D};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 256'd253, 256'd3, 256'd2, 248'h08};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 256'd253, 256'd3, 256'd5, 248'h7D};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 256'd253, 256'd3, 256'd7, {31{8'h11}}};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 256'd253, 256'd3, 256'd9, 248'hDF};
        for (int i = 5; i < 8; i++) begin
            vecs[i].new_key  = 1'b1;
            vecs[i].bp       = 1'($urandom_range(0, 1));
            vecs[i].rnd_rx   = 1'($urandom_range(0, 1));
            vecs[i].hold_rx  = 1'b0;
            vecs[i].override = 1'b0;
            vecs[i].n        = 256'($urandom | 32'h8000_0001);
            vecs[i].e        = 256'($urandom_range(1, 65535));
            vecs[i].a        = 256'($urandom) % vecs[i].n;
            vecs[i].expect_pt = modexp(vecs[i].a, vecs[i].e, vecs[i].n)
                                [247:0];
        end
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Reset while waiting on the core; its late finished pulse must be ignored.
        expect_live = 1'b0;
        do_reset();
        send_bytes(256'd253, 0, 32, 1'b0);
        send_bytes(256'd3, 0, 32, 1'b0);
        starts_before = start_count;
        send_bytes(256'd5, 0, 32, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("wait_rst_tx_valid", 256'(tx_valid), 256'(0));
        checkOutput("wait_rst_rx_ready", 256'(rx_ready), 256'(1));
        checkOutput("wait_rst_core_n", core_n, 256'd0);
        checkOutput("wait_rst_core_a", core_a, 256'd0);
        tx_hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_valid) tx_hi++;
        end
        checkOutput("wait_rst_finished_ignored", 256'(tx_hi), 256'(0));
        checkOutput("wait_rst_start_count", 256'(start_count - starts_before), 256'(1));

        // Reset in the middle of transmit, after ten bytes have gone out.
        expect_live = 1'b1;
        override_top = 1'b0;
        do_reset();
        send_bytes(256'd253, 0, 32, 1'b0);
        send_bytes(256'd3, 0, 32, 1'b0);
        send_bytes(256'd5, 0, 32, 1'b0);
        recv_block(248'h7D, 1'b0, 1'b0, 256'd5, 10, 1'b0);
        @(negedge clk);
        tx_ready = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("tx_rst_tx_valid", 256'(tx_valid), 256'(0));
        checkOutput("tx_rst_tx_data", 256'(tx_data), 256'(0));
        checkOutput("tx_rst_rx_ready", 256'(rx_ready), 256'(1));
        checkOutput("tx_rst_core_e", core_e, 256'd0);
        tx_hi = 0;
        tx_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid) tx_hi++;
        end
        tx_ready = 1'b0;
        checkOutput("tx_rst_no_resume", 256'(tx_hi), 256'(0));

        // Spurious finished pulses while receiving must not disturb byte alignment.
        expect_live = 1'b0;
        do_reset();
        send_bytes(256'd253, 0, 16, 1'b0);
        @(negedge clk) spur_finished = 1'b1;
        @(negedge clk) spur_finished = 1'b0;
        checkOutput("spur_n_tx_valid", 256'(tx_valid), 256'(0));
        send_bytes(256'd253, 16, 16, 1'b0);
        send_bytes(256'd3, 0, 32, 1'b0);
        send_bytes(256'd5, 0, 10, 1'b0);
        @(negedge clk) spur_finished = 1'b1;
        @(negedge clk) spur_finished = 1'b0;
        checkOutput("spur_c_tx_valid", 256'(tx_valid), 256'(0));
        expect_live = 1'b1;
        send_bytes(256'd5, 10, 22, 1'b0);
        checkOutput("spur_start_pulse", 256'(core_start), 256'(1));
        checkOutput("spur_core_n", core_n, 256'd253);
        checkOutput("spur_core_a", core_a, 256'd5);
        recv_block(248'h7D, 1'b0, 1'b0, 256'd5, 31, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
